// File: rtl/vjtag_scan_master.sv
`timescale 1ns/1ps
// Host-side virtual-JTAG scan driver: one command becomes UIR, CDR, SDR x len, UDR, RTI, RESP.
// Define VJTAG_SCAN_TDO_CHECK_EN to add cmd_exp/cmd_mask inputs and the rsp_mismatch output.

module vjtag_scan_master #(
  parameter int unsigned IR_WIDTH = 2,
  parameter int unsigned DR_WIDTH = 38,
  parameter int unsigned TCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  input  logic [5:0]          cmd_len,
`ifdef VJTAG_SCAN_TDO_CHECK_EN
  input  logic [DR_WIDTH-1:0] cmd_exp,
  input  logic [DR_WIDTH-1:0] cmd_mask,
  output logic                rsp_mismatch,
`endif
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  input  logic [IR_WIDTH-1:0] ir_out,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti
);

  localparam int unsigned     PeriodLen  = 2 * TCK_DIV;
  localparam int unsigned     CntW       = $clog2(PeriodLen);
  localparam logic [CntW-1:0] CntLast    = CntW'(PeriodLen - 1);
  localparam logic [CntW-1:0] CntRise    = CntW'(TCK_DIV);
  localparam logic [CntW-1:0] CntPreRise = CntW'(TCK_DIV - 1);
  localparam logic [5:0]      LenMax     = 6'(DR_WIDTH);

  typedef enum logic [2:0] {
    StIdle, StUir, StCdr, StSdr, StUdr, StRti, StResp
  } state_e;

  function automatic logic in_scan(input state_e s);
    return (s == StUir) || (s == StCdr) || (s == StSdr) || (s == StUdr) || (s == StRti);
  endfunction

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [5:0]          bit_q, bit_d;
  logic [5:0]          len_q, len_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [IR_WIDTH-1:0] irc_q, irc_d;
  logic [DR_WIDTH-1:0] sh_q, sh_d;
  logic [DR_WIDTH-1:0] cap_q, cap_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                tck_q, tck_d;
  logic                tdi_q, tdi_d;
  logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
  logic [4:0]          strb_q, strb_d;

  logic active, rise, per_end;

  assign active  = in_scan(state_q);
  assign rise    = active && (cnt_q == CntPreRise);
  assign per_end = active && (cnt_q == CntLast);

`ifdef VJTAG_SCAN_TDO_CHECK_EN
  logic [DR_WIDTH-1:0] exp_q, exp_d;
  logic [DR_WIDTH-1:0] mask_q, mask_d;
  logic [DR_WIDTH-1:0] len_mask;
  logic                mis_q, mis_d;

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < DR_WIDTH; i++) begin
      len_mask[i] = (6'(i) < len_q);
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    len_d       = len_q;
    ir_d        = ir_q;
    irc_d       = irc_q;
    sh_d        = sh_q;
    cap_d       = cap_q;
    rsp_valid_d = rsp_valid_q;
`ifdef VJTAG_SCAN_TDO_CHECK_EN
    exp_d       = exp_q;
    mask_d      = mask_q;
    mis_d       = mis_q;
`endif

    if (active) begin
      cnt_d = per_end ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d = StUir;
          cnt_d   = '0;
          bit_d   = '0;
          len_d   = (cmd_len > LenMax) ? LenMax : cmd_len;
          ir_d    = cmd_ir;
          sh_d    = cmd_dr;
          cap_d   = '0;
`ifdef VJTAG_SCAN_TDO_CHECK_EN
          exp_d   = cmd_exp;
          mask_d  = cmd_mask;
          mis_d   = 1'b0;
`endif
        end
      end
      StUir: begin
        if (rise) irc_d = ir_out;
        if (per_end) state_d = (len_q == 6'd0) ? StRti : StCdr;
      end
      StCdr: begin
        if (per_end) state_d = StSdr;
      end
      StSdr: begin
        // The node shifts on tck rise, so tdo is captured on the same clk.
        if (rise) begin
          for (int i = 0; i < DR_WIDTH; i++) begin
            if (bit_q == 6'(i)) cap_d[i] = tdo;
          end
        end
        if (per_end) begin
          sh_d = sh_q >> 1;
          if (bit_q == len_q - 6'd1) state_d = StUdr;
          else                       bit_d   = bit_q + 6'd1;
        end
      end
      StUdr: begin
        if (per_end) state_d = StRti;
      end
      StRti: begin
        if (per_end) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
`ifdef VJTAG_SCAN_TDO_CHECK_EN
          mis_d       = |((cap_q ^ exp_q) & mask_q & len_mask);
`endif
        end
      end
      StResp: begin
        // One extra cycle after the handshake before IDLE re-opens cmd_ready.
        if (rsp_valid_q) begin
          if (rsp_ready) rsp_valid_d = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Pin outputs are registered from next-state values so they align with state_q.
    tck_d   = in_scan(state_d) && (cnt_d >= CntRise);
    tdi_d   = (state_d == StSdr) && sh_d[0];
    ir_in_d = in_scan(state_d) ? ir_d : '0;
    strb_d  = {state_d == StRti, state_d == StUdr, state_d == StSdr,
               state_d == StCdr, state_d == StUir};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      len_q       <= '0;
      ir_q        <= '0;
      irc_q       <= '0;
      sh_q        <= '0;
      cap_q       <= '0;
      rsp_valid_q <= 1'b0;
      tck_q       <= 1'b0;
      tdi_q       <= 1'b0;
      ir_in_q     <= '0;
      strb_q      <= '0;
`ifdef VJTAG_SCAN_TDO_CHECK_EN
      exp_q       <= '0;
      mask_q      <= '0;
      mis_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      len_q       <= len_d;
      ir_q        <= ir_d;
      irc_q       <= irc_d;
      sh_q        <= sh_d;
      cap_q       <= cap_d;
      rsp_valid_q <= rsp_valid_d;
      tck_q       <= tck_d;
      tdi_q       <= tdi_d;
      ir_in_q     <= ir_in_d;
      strb_q      <= strb_d;
`ifdef VJTAG_SCAN_TDO_CHECK_EN
      exp_q       <= exp_d;
      mask_q      <= mask_d;
      mis_q       <= mis_d;
`endif
    end
  end

  assign cmd_ready      = (state_q == StIdle);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_dr         = cap_q;
  assign rsp_ir_out     = irc_q;
  assign tck            = tck_q;
  assign tdi            = tdi_q;
  assign ir_in          = ir_in_q;
  assign vs_uir         = strb_q[0];
  assign vs_cdr         = strb_q[1];
  assign vs_sdr         = strb_q[2];
  assign vs_udr         = strb_q[3];
  assign jtag_state_rti = strb_q[4];
`ifdef VJTAG_SCAN_TDO_CHECK_EN
  assign rsp_mismatch   = mis_q;
`endif

endmodule
